// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one cacheline adaptor port.
// Define ARB_ROUND_ROBIN_EN for alternating priority; otherwise the D-cache always wins ties.
module cache_arbiter (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_read_i,
  input  logic [31:0]  i_addr_i,
  output logic [255:0] i_rdata_o,
  output logic         i_resp_o,
  input  logic         d_read_i,
  input  logic         d_write_i,
  input  logic [31:0]  d_addr_i,
  input  logic [255:0] d_wdata_i,
  output logic [255:0] d_rdata_o,
  output logic         d_resp_o,
  output logic         m_read_o,
  output logic         m_write_o,
  output logic [31:0]  m_addr_o,
  output logic [255:0] m_wdata_o,
  input  logic [255:0] m_rdata_i,
  input  logic         m_resp_i
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD, StDone} state_e;

  state_e        state_q;
  logic [31:0]   addr_q;
  logic [255:0]  wdata_q;
  logic          read_q;
  logic          write_q;
  logic          d_req;
  logic          pick_d;
  logic          pick_i;
  logic          serving;

  assign d_req   = d_read_i | d_write_i;
  assign serving = (state_q == StServeI) || (state_q == StServeD);

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_dcache_q;

  // Pointer moves to whichever requester was not just served.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_dcache_q <= 1'b1;
    end else if (serving && m_resp_i) begin
      ptr_dcache_q <= (state_q == StServeI);
    end
  end

  always_comb begin
    pick_d = 1'b0;
    pick_i = 1'b0;
    if (d_req && i_read_i) begin
      pick_d = ptr_dcache_q;
      pick_i = ~ptr_dcache_q;
    end else begin
      pick_d = d_req;
      pick_i = i_read_i;
    end
  end
`else
  always_comb begin
    pick_d = d_req;
    pick_i = i_read_i & ~d_req;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_d) begin
            state_q <= StServeD;
            addr_q  <= d_addr_i;
            wdata_q <= d_write_i ? d_wdata_i : '0;
            // A simultaneous read and write is treated as a write-back.
            read_q  <= ~d_write_i;
            write_q <= d_write_i;
          end else if (pick_i) begin
            state_q <= StServeI;
            addr_q  <= i_addr_i;
            wdata_q <= '0;
            read_q  <= 1'b1;
            write_q <= 1'b0;
          end
        end
        StServeI, StServeD: begin
          if (m_resp_i) begin
            state_q <= StDone;
            addr_q  <= '0;
            wdata_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held, before the registers clear.
  assign m_read_o  = read_q & ~rst_i;
  assign m_write_o = write_q & ~rst_i;
  assign m_addr_o  = rst_i ? 32'd0 : addr_q;
  assign m_wdata_o = rst_i ? 256'd0 : wdata_q;

  assign i_resp_o  = (state_q == StServeI) & m_resp_i & ~rst_i;
  assign d_resp_o  = (state_q == StServeD) & m_resp_i & ~rst_i;
  assign i_rdata_o = m_rdata_i;
  assign d_rdata_o = m_rdata_i;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level arbitration model.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         m_read;
  logic         m_write;
  logic [31:0]  m_addr;
  logic [255:0] m_wdata;
  logic [255:0] m_rdata;
  logic         m_resp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .i_read_i  (i_read),
    .i_addr_i  (i_addr),
    .i_rdata_o (i_rdata),
    .i_resp_o  (i_resp),
    .d_read_i  (d_read),
    .d_write_i (d_write),
    .d_addr_i  (d_addr),
    .d_wdata_i (d_wdata),
    .d_rdata_o (d_rdata),
    .d_resp_o  (d_resp),
    .m_read_o  (m_read),
    .m_write_o (m_write),
    .m_addr_o  (m_addr),
    .m_wdata_o (m_wdata),
    .m_rdata_i (m_rdata),
    .m_resp_i  (m_resp)
  );

  task automatic drop_req(input bit is_d);
    if (is_d) begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // One adaptor transaction for an already-requesting cache. lat counts serve cycles
  // including the m_resp cycle (>= 2); the grant must appear within max_wait cycles.
  task automatic run_txn(input bit is_d, input logic [31:0] addr, input bit wr,
                         input logic [255:0] wdata, input int lat, input logic [255:0] rdata,
                         input int drop_at, input int max_wait);
    bit got = 1'b0;
    for (int k = 0; k < max_wait && !got; k++) begin
      @(negedge clk);
      if (m_read || m_write) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL grant_timeout: no m_read/m_write within %0d cycles (want addr %h)",
               max_wait, addr);
      return;
    end
    checks++;
    if (m_addr !== addr || m_write !== wr || m_read !== !wr) begin
      failures++;
      $display("FAIL grant: got addr=%h rd=%b wr=%b, want addr=%h rd=%b wr=%b",
               m_addr, m_read, m_write, addr, !wr, wr);
    end
    if (wr) begin
      checks++;
      if (m_wdata !== wdata) begin
        failures++;
        $display("FAIL wdata: got %h want %h", m_wdata, wdata);
      end
    end
    for (int k = 1; k <= lat - 2; k++) begin
      @(posedge clk);
      #1;
      if (k == drop_at) drop_req(is_d);
      @(negedge clk);
      checks++;
      if (m_addr !== addr || m_read !== !wr || m_write !== wr || i_resp !== 1'b0 ||
          d_resp !== 1'b0) begin
        failures++;
        $display("FAIL hold: got addr=%h rd=%b wr=%b iresp=%b dresp=%b, want addr=%h held",
                 m_addr, m_read, m_write, i_resp, d_resp, addr);
      end
    end
    @(posedge clk);
    #1;
    m_resp  = 1'b1;
    m_rdata = rdata;
    @(negedge clk);
    checks++;
    if (i_resp !== !is_d || d_resp !== is_d) begin
      failures++;
      $display("FAIL resp_route: got iresp=%b dresp=%b, want iresp=%b dresp=%b",
               i_resp, d_resp, !is_d, is_d);
    end
    checks++;
    if ((is_d ? d_rdata : i_rdata) !== rdata) begin
      failures++;
      $display("FAIL rdata: got %h want %h", is_d ? d_rdata : i_rdata, rdata);
    end
    @(posedge clk);
    #1;
    m_resp  = 1'b0;
    m_rdata = {8{$urandom}};
    drop_req(is_d);
    @(negedge clk);
    checks++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
      failures++;
      $display("FAIL done: got rd=%b wr=%b iresp=%b dresp=%b, want all 0",
               m_read, m_write, i_resp, d_resp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    i_read = 1'b1;
    d_read = 1'b1;
    m_resp = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({m_read, m_write, i_resp, d_resp} !== 4'b0 || m_addr !== 32'd0 || m_wdata !== 256'd0)
      begin
        failures++;
        $display("FAIL reset_hold: got rd=%b wr=%b iresp=%b dresp=%b addr=%h, want all 0",
                 m_read, m_write, i_resp, d_resp, m_addr);
      end
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    i_read = 1'b0;
    d_read = 1'b0;
    m_resp = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_read, m_write, i_resp, d_resp} !== 4'b0 || m_addr !== 32'd0 || m_wdata !== 256'd0)
    begin
      failures++;
      $display("FAIL reset_after: got rd=%b wr=%b iresp=%b dresp=%b addr=%h, want all 0",
               m_read, m_write, i_resp, d_resp, m_addr);
    end
  endtask

  task automatic test_lone_i();
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    @(posedge clk);
    #1;
    i_read = 1'b1;
    i_addr = 32'h60;
    @(negedge clk);
    checks++;
    if (m_read !== 1'b0) begin
      failures++;
      $display("FAIL lone_i_cycle0: got m_read=%b want 0", m_read);
    end
    run_txn(1'b0, 32'h60, 1'b0, 256'd0, 5, a5, 0, 1);
    // Request raised during DONE must wait for the IDLE cycle that follows.
    d_read = 1'b1;
    d_addr = 32'h240;
    @(negedge clk);
    checks++;
    if (m_read !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle: got m_read=%b in idle cycle, want 0", m_read);
    end
    run_txn(1'b1, 32'h240, 1'b0, 256'd0, 2, {8{32'hC0FFEE11}}, 0, 1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h100;
    d_read = 1'b1;
    d_addr = 32'h200;
    // Pointer starts at D after reset, so both policies serve D first here.
    run_txn(1'b1, 32'h200, 1'b0, 256'd0, 3, {8{32'h0D0D0D0D}}, 0, 2);
    run_txn(1'b0, 32'h100, 1'b0, 256'd0, 2, {8{32'h11111111}}, 0, 2);
  endtask

  task automatic test_write_back();
    @(negedge clk);
    d_write = 1'b1;
    d_addr  = 32'h80;
    d_wdata = 256'h1234;
    run_txn(1'b1, 32'h80, 1'b1, 256'h1234, 4, {8{$urandom}}, 0, 1);
  endtask

  task automatic test_drop();
    @(negedge clk);
    i_read = 1'b1;
    i_addr = 32'h300;
    run_txn(1'b0, 32'h300, 1'b0, 256'd0, 6, {8{32'hBEEF0001}}, 2, 1);
  endtask

  task automatic test_spurious_resp();
    @(negedge clk);
    m_resp  = 1'b1;
    m_rdata = {8{32'hDEADBEEF}};
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({m_read, m_write, i_resp, d_resp} !== 4'b0) begin
        failures++;
        $display("FAIL idle_resp: got rd=%b wr=%b iresp=%b dresp=%b, want all 0",
                 m_read, m_write, i_resp, d_resp);
      end
    end
    m_resp = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_read = 1'b1;
    d_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (m_read !== 1'b1 || m_addr !== 32'h40) begin
      failures++;
      $display("FAIL rst_mid_serve: got rd=%b addr=%h want rd=1 addr=00000040", m_read, m_addr);
    end
    @(posedge clk);
    #1;
    rst    = 1'b1;
    m_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (m_read !== 1'b0 || d_resp !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_hold: got rd=%b dresp=%b want 0 0", m_read, d_resp);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_resp = 1'b0;
    d_read = 1'b0;
    @(negedge clk);
    checks++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || m_addr !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_after: got rd=%b wr=%b addr=%h want 0 0 0", m_read, m_write, m_addr);
    end
    @(posedge clk);
    #1;
    m_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (d_resp !== 1'b0 || m_read !== 1'b0) begin
      failures++;
      $display("FAIL late_resp: got dresp=%b rd=%b want 0 0", d_resp, m_read);
    end
    @(posedge clk);
    #1;
    m_resp = 1'b0;
  endtask

  task automatic test_random();
    bit ptr_d = 1'b1;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      bit has_i, has_d, d_wr, first_d;
      int op;
      logic [31:0] ia, da;
      logic [255:0] wd;
      has_i = 1'b0;
      has_d = 1'b0;
      case ($urandom_range(1, 3))
        1: has_i = 1'b1;
        2: has_d = 1'b1;
        default: begin has_i = 1'b1; has_d = 1'b1; end
      endcase
      op = $urandom_range(0, 2);
      d_wr = (op != 0);
      ia = {$urandom_range(0, 32'h07FF_FFFF), 5'd0};
      da = {$urandom_range(0, 32'h07FF_FFFF), 5'd0};
      wd = {8{$urandom}};
      @(negedge clk);
      i_read  = has_i;
      i_addr  = ia;
      d_read  = has_d && (op != 1);
      d_write = has_d && d_wr;
      d_addr  = da;
      d_wdata = wd;
`ifdef ARB_ROUND_ROBIN_EN
      first_d = has_d && (!has_i || ptr_d);
`else
      first_d = has_d;
`endif
      if (first_d) begin
        run_txn(1'b1, da, d_wr, wd, $urandom_range(2, 5), {8{$urandom}}, 0, 1);
        ptr_d = 1'b0;
        if (has_i) begin
          run_txn(1'b0, ia, 1'b0, 256'd0, $urandom_range(2, 5), {8{$urandom}}, 0, 2);
          ptr_d = 1'b1;
        end
      end else begin
        run_txn(1'b0, ia, 1'b0, 256'd0, $urandom_range(2, 5), {8{$urandom}}, 0, 1);
        ptr_d = 1'b1;
        if (has_d) begin
          run_txn(1'b1, da, d_wr, wd, $urandom_range(2, 5), {8{$urandom}}, 0, 2);
          ptr_d = 1'b0;
        end
      end
    end
  endtask

  // Protocol invariants on every cycle outside reset.
  always @(negedge clk) begin
    if (!rst && ((i_resp && d_resp) || (m_read && m_write))) begin
      failures++;
      $display("FAIL exclusive: iresp=%b dresp=%b rd=%b wr=%b", i_resp, d_resp, m_read, m_write);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    m_resp  = 1'b0;
    test_reset();
    test_lone_i();
    test_simultaneous();
    test_write_back();
    test_drop();
    test_spurious_resp();
    test_lone_i();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
